// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - RAM state and arbiter types shared by the cache/memory arbiter
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

package diaosi_types_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_req_t;

    localparam logic [31:0] ARB_ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - icache/dcache request and RAM port bundle for the arbiter
interface cache_mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic                     iREN;
    logic [WORD_W-1:0]        iaddr;
    logic                     iwait;
    logic [WORD_W-1:0]        iload;
    logic                     dREN;
    logic                     dWEN;
    logic [WORD_W-1:0]        daddr;
    logic [WORD_W-1:0]        dstore;
    logic                     dwait;
    logic [WORD_W-1:0]        dload;
    logic                     ramREN;
    logic                     ramWEN;
    logic [WORD_W-1:0]        ramaddr;
    logic [WORD_W-1:0]        ramstore;
    logic [WORD_W-1:0]        ramload;
    cpu_types_pkg::ramstate_t ramstate;
    logic                     arb_timeout;
    logic                     arb_error;

    // Arbiter side: takes cache requests and RAM responses, drives everything else.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               arb_timeout, arb_error
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               arb_timeout, arb_error
    );
endinterface

// File: rtl/cache_mem_arbiter_watchdog.sv
// rtl/cache_mem_arbiter_watchdog.sv - grant-cycle counter with a sticky timeout flag
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic count_en,
    output logic timeout
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] count;

    // Count saturates at LIMIT so a long stall cannot wrap and look fresh.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            if (!count_en) begin
                count <= '0;
            end else if (count != LIMIT) begin
                count <= count + 16'd1;
            end
            if (count_en && (count == LIMIT - 16'd1)) begin
                timeout <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache to single-port RAM arbiter; ARB_FAIR_EN enables alternating grants
module cache_mem_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.slave  bus
);
    arb_state_t        state;
    arb_state_t        next_state;
    logic              err_done;
    logic              ram_done;
    logic              d_req;
    logic              i_req;
    logic              pick_d;
    logic [WORD_W-1:0] rdata;
    logic              arb_error_q;

    assign d_req    = bus.dREN | bus.dWEN;
    assign i_req    = bus.iREN;
    assign ram_done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    assign rdata    = (bus.ramstate == ERROR) ? WORD_W'(ARB_ERR_WORD) : bus.ramload;

`ifdef ARB_FAIR_EN
    arb_req_t last_grant;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_grant <= ICACHE;
        end else if (state == IDLE) begin
            if (next_state == IGRANT) begin
                last_grant <= ICACHE;
            end else if (next_state == DGRANT) begin
                last_grant <= DCACHE;
            end
        end
    end

    // Under contention the requester not served last goes first.
    assign pick_d = (d_req && i_req) ? (last_grant == ICACHE) : d_req;
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            arb_error_q <= 1'b0;
        end else begin
            state <= next_state;
            if (err_done) begin
                arb_error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state   = state;
        err_done     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    next_state = DGRANT;
                end else if (i_req) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!i_req) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    bus.iwait  = 1'b0;
                    bus.iload  = rdata;
                    err_done   = (bus.ramstate == ERROR);
                    next_state = IDLE;
                end
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    bus.dwait  = 1'b0;
                    bus.dload  = rdata;
                    err_done   = (bus.ramstate == ERROR);
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Reset masks the RAM port and any completion, even mid-transaction.
        if (!nRST) begin
            err_done     = 1'b0;
            bus.ramREN   = 1'b0;
            bus.ramWEN   = 1'b0;
            bus.ramaddr  = '0;
            bus.ramstore = '0;
            bus.iwait    = 1'b1;
            bus.dwait    = 1'b1;
            bus.iload    = '0;
            bus.dload    = '0;
        end
    end

    assign bus.arb_error = arb_error_q;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .count_en (state != IDLE),
        .timeout  (bus.arb_timeout)
    );
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter with a RAM/transaction model
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   passed;
    int   failed;
    int   total;
    logic exp_err;
    logic m_last;
    logic [31:0] mem [64];

    cache_mem_arbiter_if #(.WORD_W(32)) bus ();

    cache_mem_arbiter #(
        .WORD_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic pick_d(input logic ireq, input logic dreq);
`ifdef ARB_FAIR_EN
        if (ireq && dreq) return (m_last == 1'b0);
`endif
        return dreq;
    endfunction

    // One transaction from the idle cycle through completion; winner's request drops afterwards.
    task automatic serve(input logic is_d, input int lat, input logic err);
        logic [31:0] a;
        logic [31:0] ld;
        logic        wr;
        logic        last;
        a  = is_d ? bus.daddr : bus.iaddr;
        wr = is_d & bus.dWEN;
        m_last = is_d;
        bus.ramstate = BUSY;
        @(negedge CLK);
        chk("idle_ramREN", bus.ramREN, 0);
        chk("idle_ramWEN", bus.ramWEN, 0);
        chk("idle_iwait", bus.iwait, 1);
        chk("idle_dwait", bus.dwait, 1);
        tick();
        for (int k = 0; k <= lat; k++) begin
            last = (k == lat);
            if (!last) bus.ramstate = BUSY;
            else if (err) bus.ramstate = ERROR;
            else bus.ramstate = ACCESS;
            bus.ramload = err ? $urandom : mem[a[7:2]];
            ld = err ? 32'hBAD1BAD1 : bus.ramload;
            @(negedge CLK);
            chk("ramaddr", bus.ramaddr, a);
            chk("ramREN", bus.ramREN, !wr);
            chk("ramWEN", bus.ramWEN, wr);
            if (wr) chk("ramstore", bus.ramstore, bus.dstore);
            chk("iwait", bus.iwait, !(last && !is_d));
            chk("dwait", bus.dwait, !(last && is_d));
            if (last) chk(is_d ? "dload" : "iload", is_d ? bus.dload : bus.iload, ld);
            chk(is_d ? "iload_ungranted" : "dload_ungranted", is_d ? bus.iload : bus.dload, 0);
            chk("arb_error", bus.arb_error, exp_err);
            chk("arb_timeout", bus.arb_timeout, 0);
            tick();
        end
        if (err) exp_err = 1'b1;
        else if (wr) mem[a[7:2]] = bus.dstore;
        if (is_d) begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
        end else begin
            bus.iREN = 1'b0;
        end
        bus.ramstate = BUSY;
    endtask

    initial begin
        logic w;
        int   r;
        int   op;
        passed  = 0;
        failed  = 0;
        total   = 0;
        exp_err = 1'b0;
        m_last  = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[16] = 32'h2402000A;

        nRST         = 1'b0;
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.iaddr    = 32'h0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = BUSY;

        repeat (2) begin
            @(negedge CLK);
            chk("rst_ramREN", bus.ramREN, 0);
            chk("rst_ramWEN", bus.ramWEN, 0);
            chk("rst_iwait", bus.iwait, 1);
            chk("rst_dwait", bus.dwait, 1);
            chk("rst_iload", bus.iload, 0);
            chk("rst_dload", bus.dload, 0);
            @(posedge CLK);
        end
        #1;
        nRST     = 1'b1;
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        @(negedge CLK);
        chk("post_rst_timeout", bus.arb_timeout, 0);
        chk("post_rst_error", bus.arb_error, 0);
        chk("post_rst_ramREN", bus.ramREN, 0);
        tick();

        // Icache read, ACCESS on the second grant cycle.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        serve(1'b0, 1, 1'b0);

        // Contention: dcache write against icache read.
        bus.iREN   = 1'b1;
        bus.iaddr  = 32'h40;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h80;
        bus.dstore = 32'hDEADBEEF;
        w = pick_d(1'b1, 1'b1);
        serve(w, 0, 1'b0);
        serve(!w, 0, 1'b0);

        // RAM error on a dcache read.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h84;
        serve(1'b1, 0, 1'b1);
        @(negedge CLK);
        chk("error_sticky", bus.arb_error, 1);
        tick();

        // Abort: dREN dropped while granted.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h88;
        tick();
        m_last = 1'b1;
        @(negedge CLK);
        chk("abort_grant_ramREN", bus.ramREN, 1);
        chk("abort_grant_dwait", bus.dwait, 1);
        tick();
        bus.dREN     = 1'b0;
        bus.ramstate = ACCESS;
        @(negedge CLK);
        chk("abort_drop_dwait", bus.dwait, 1);
        tick();
        @(negedge CLK);
        chk("abort_idle_ramREN", bus.ramREN, 0);
        chk("abort_idle_ramWEN", bus.ramWEN, 0);
        chk("abort_idle_dwait", bus.dwait, 1);
        tick();
        bus.ramstate = BUSY;

        // Reset during IGRANT.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h44;
        tick();
        @(negedge CLK);
        chk("rstmid_grant_ramREN", bus.ramREN, 1);
        tick();
        nRST         = 1'b0;
        bus.ramstate = ACCESS;
        @(negedge CLK);
        chk("rstmid_iwait", bus.iwait, 1);
        chk("rstmid_ramREN", bus.ramREN, 0);
        chk("rstmid_iload", bus.iload, 0);
        tick();
        nRST         = 1'b1;
        bus.iREN     = 1'b0;
        bus.ramstate = BUSY;
        exp_err      = 1'b0;
        m_last       = 1'b0;
        @(negedge CLK);
        chk("rstmid_after_ramREN", bus.ramREN, 0);
        chk("rstmid_after_iwait", bus.iwait, 1);
        chk("rstmid_after_error", bus.arb_error, 0);
        tick();

        // Randomized traffic against the RAM model.
        for (int n = 0; n < 40; n++) begin
            if (!bus.iREN && !(bus.dREN || bus.dWEN)) begin
                r = $urandom_range(0, 2);
                if (r != 1) begin
                    bus.iREN  = 1'b1;
                    bus.iaddr = {24'h0, 6'($urandom), 2'b00};
                end
                if (r != 0) begin
                    op         = $urandom_range(0, 2);
                    bus.dREN   = (op != 1);
                    bus.dWEN   = (op != 0);
                    bus.daddr  = {24'h0, 6'($urandom), 2'b00};
                    bus.dstore = $urandom;
                end
            end
            w = pick_d(bus.iREN, bus.dREN | bus.dWEN);
            serve(w, $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
        end
        if (bus.iREN || bus.dREN || bus.dWEN) begin
            serve(bus.dREN | bus.dWEN, 0, 1'b0);
        end

        // Watchdog: icache held against a permanently BUSY RAM.
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h10;
        bus.ramstate = BUSY;
        tick();
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk("wd_timeout", bus.arb_timeout, (k >= 5));
            chk("wd_iwait", bus.iwait, 1);
            tick();
        end
        bus.iREN = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the icache and the dcache, and upstream of the single-port RAM.
- Accepts word read requests from the icache and word read/write requests from the dcache.
- Grants one requester at a time and drives the RAM port.
- Returns data and wait handshakes to both caches.
- Registered grant state machine with a stuck-transaction watchdog.

Parameters:
- WORD_W, 32, data and address width in bits.
- TIMEOUT_CYCLES, 255, number of grant cycles without completion before the timeout flag sets (range 1..65535).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache word address.
- iwait  out  1  icache wait; low for exactly the completing cycle.
- iload  out  WORD_W  icache read data; valid when iwait is low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  WORD_W  dcache word address.
- dstore  in  WORD_W  dcache write data.
- dwait  out  1  dcache wait; low for exactly the completing cycle.
- dload  out  WORD_W  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- arb_timeout  out  1  sticky watchdog flag.
- arb_error  out  1  sticky RAM-error flag.

Behaviour:
- Reset (nRST low at a clock edge):
  - state = IDLE, watchdog count = 0, arb_timeout = 0, arb_error = 0.
  - Outputs during reset: ramREN = ramWEN = 0, iwait = dwait = 1, iload = dload = 0.
  - Reset mid-transaction abandons the transaction with no completion pulse.
- States: IDLE, IGRANT, DGRANT.
- IDLE:
  - RAM enables are 0.
  - Next state: DGRANT if (dREN | dWEN); else IGRANT if iREN; else IDLE.
  - The dcache has fixed priority over the icache.
- IGRANT:
  - ramREN = 1, ramWEN = 0, ramaddr = iaddr.
- DGRANT:
  - ramaddr = daddr, ramstore = dstore.
  - ramWEN = dWEN; ramREN = dREN & ~dWEN.
  - If dREN and dWEN are both high, the write wins.
- Completion in a grant state (ramstate == ACCESS):
  - The granted wait goes low combinationally in that cycle.
  - iload or dload = ramload.
  - Next state = IDLE.
- Completion on ramstate == ERROR:
  - Handled as a completion, but load = 32'hBAD1BAD1.
  - arb_error sets on the next edge.
- Latency:
  - Request seen in cycle 0; grant state in cycle 1.
  - Minimum completion in cycle 1 (one-cycle ACCESS RAM).
  - Back-to-back requests each spend one cycle in IDLE between grants.
- Abort: if the granted requester drops its enables while granted, return to IDLE next cycle with no completion.
- Non-granted wait is held at 1. Non-granted load = 0.
- Watchdog:
  - Counts cycles in a grant state; clears in IDLE.
  - On reaching TIMEOUT_CYCLES, arb_timeout sets and stays set until reset.
  - The transaction keeps waiting; no forced completion.
- Requests change only after a wait-low cycle. Address/data changes while granted pass straight through to the RAM.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - A last_grant register is added; reset value = ICACHE.
  - When both caches request in IDLE, grant the requester opposite to last_grant.
  - Single requests are granted as normal.
- Undefined: fixed dcache priority. No last_grant register exists.

Decomposition:
- diaosi_types_pkg gains:
  - arb_state_t enum {IDLE, IGRANT, DGRANT}.
  - arb_req_t enum {ICACHE, DCACHE}.
  - constant ARB_ERR_WORD = 32'hBAD1BAD1.
- ramstate_t is taken from cpu_types_pkg.
- One sub-module: arb_watchdog (counter plus sticky flag, parameterised by TIMEOUT_CYCLES).

Test Plan:
- Reset: hold nRST low 2 cycles with all requests high -> ramREN = ramWEN = 0, iwait = dwait = 1, flags = 0.
- Icache read:
  - Stimulus: iREN = 1, iaddr = 0x40; RAM returns ACCESS on the 2nd grant cycle with ramload = 0x2402000A.
  - Response: ramaddr = 0x40, ramREN = 1; iwait low for one cycle with iload = 0x2402000A.
- Contention:
  - Stimulus: iREN = 1 and dWEN = 1 (daddr = 0x80, dstore = 0xDEADBEEF) in the same cycle.
  - Response: DGRANT first with ramWEN = 1 and ramstore = 0xDEADBEEF; then IDLE, then IGRANT.
  - With ARB_FAIR_EN and last_grant = DCACHE: IGRANT first.
- Error:
  - Stimulus: dREN = 1; ramstate = ERROR.
  - Response: dwait low for one cycle, dload = 0xBAD1BAD1, arb_error = 1 thereafter.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES = 4; ramstate stays BUSY with iREN held.
  - Response: arb_timeout rises after 4 grant cycles; iwait stays 1.
- Abort and reset mid-op:
  - Drop dREN during DGRANT -> IDLE next cycle, no dwait pulse.
  - Assert nRST low during IGRANT -> IDLE, and no completion pulse on iwait.
